daq_link_adapter: RTL and testbench

Downstream stage of the DAQ event builder. Accepts the 64-bit header/data/trailer word stream (valid/ready) and buffers it in a small FIFO. Drains the FIFO into the DAQ link interface, which uses write-enable with almost-full backpressure. Tracks event framing and reports event count, last event length and protocol errors to the control registers.

---
 rtl/daq_link_adapter.sv | 186 ++++++++++++++++++
 tb/tb_daq_link_adapter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_link_adapter.sv
// DAQ link adapter: buffers the event word stream in a FIFO, drains it to the DAQ link and tracks event framing.
// Optional build macro DAQ_TRAILER_LEN_EN stamps the event word count into trailer bits [51:32].
module daq_link_adapter #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] in_data,
    input  logic        in_header,
    input  logic        in_trailer,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] link_data,
    output logic        link_header,
    output logic        link_trailer,
    output logic        link_we,
    input  logic        link_almost_full,
    input  logic        link_ready,
    output logic [31:0] evt_count,
    output logic [19:0] last_evt_words,
    output logic        proto_err,
    input  logic        err_clr
);

    localparam logic [DEPTH_LOG2:0]   DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        OUT_EVT = 1'b0,
        IN_EVT  = 1'b1
    } state_t;

    logic [65:0]           mem_q [(1 << DEPTH_LOG2)];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  in_ready_q;
    logic                  af_q, lrdy_q;
    state_t                state_q, state_d;
    logic [19:0]           word_cnt_q, word_cnt_d, cnt_inc_s;
    logic [19:0]           last_q, last_d;
    logic [31:0]           evt_q, evt_d;
    logic                  perr_q, perr_d;
    logic [63:0]           link_data_q;
    logic                  link_header_q, link_trailer_q, link_we_q;
    logic                  acc_s, wr_s, pop_s, set_err_s;
    logic [63:0]           wr_word_s;

    // Framing decisions for the accepted word: write/drop, error, counters.
    always_comb begin
        acc_s      = in_valid && in_ready_q;
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        last_d     = last_q;
        evt_d      = evt_q;
        set_err_s  = 1'b0;
        wr_s       = 1'b0;
        wr_word_s  = in_data;
        cnt_inc_s  = (word_cnt_q == 20'hFFFFF) ? word_cnt_q : word_cnt_q + 20'd1;
        if (acc_s) begin
            if (in_header && in_trailer) begin
                set_err_s = 1'b1;
            end else if (in_header) begin
                wr_s       = 1'b1;
                word_cnt_d = 20'd1;
                state_d    = IN_EVT;
                if (state_q == IN_EVT) begin
                    set_err_s = 1'b1;
                end else begin
                    set_err_s = 1'b0;
                end
            end else begin
                case (state_q)
                    OUT_EVT: begin
                        set_err_s = 1'b1;
                    end
                    IN_EVT: begin
                        wr_s = 1'b1;
                        if (in_trailer) begin
                            last_d     = cnt_inc_s;
                            evt_d      = evt_q + 32'd1;
                            word_cnt_d = cnt_inc_s;
                            state_d    = OUT_EVT;
`ifdef DAQ_TRAILER_LEN_EN
                            wr_word_s[51:32] = cnt_inc_s;
`else
                            wr_word_s = in_data;
`endif
                        end else begin
                            word_cnt_d = cnt_inc_s;
                        end
                    end
                    default: begin
                        set_err_s = 1'b1;
                        state_d   = OUT_EVT;
                    end
                endcase
            end
        end else begin
            wr_s = 1'b0;
        end
        // Setting the error outranks a simultaneous clear.
        if (set_err_s) begin
            perr_d = 1'b1;
        end else if (err_clr) begin
            perr_d = 1'b0;
        end else begin
            perr_d = perr_q;
        end
    end

    // FIFO occupancy; pops see only entries written on an earlier cycle.
    always_comb begin
        pop_s = (cnt_q != {(DEPTH_LOG2+1){1'b0}}) && lrdy_q && !af_q;
        case ({wr_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO storage, no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wr_ptr_q] <= {in_header, in_trailer, wr_word_s};
        end
    end

    // FIFO pointers, registered link-side inputs and link output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= {DEPTH_LOG2{1'b0}};
            rd_ptr_q       <= {DEPTH_LOG2{1'b0}};
            cnt_q          <= {(DEPTH_LOG2+1){1'b0}};
            in_ready_q     <= 1'b0;
            af_q           <= 1'b1;
            lrdy_q         <= 1'b0;
            link_data_q    <= 64'd0;
            link_header_q  <= 1'b0;
            link_trailer_q <= 1'b0;
            link_we_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            in_ready_q <= (cnt_d != DEPTH_C);
            af_q       <= link_almost_full;
            lrdy_q     <= link_ready;
            link_we_q  <= pop_s;
            if (wr_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q       <= rd_ptr_q + PTR_ONE;
                link_data_q    <= mem_q[rd_ptr_q][63:0];
                link_header_q  <= mem_q[rd_ptr_q][65];
                link_trailer_q <= mem_q[rd_ptr_q][64];
            end
        end
    end

    // Framing state machine and status counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OUT_EVT;
            word_cnt_q <= 20'd0;
            last_q     <= 20'd0;
            evt_q      <= 32'd0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            last_q     <= last_d;
            evt_q      <= evt_d;
            perr_q     <= perr_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign link_data      = link_data_q;
    assign link_header    = link_header_q;
    assign link_trailer   = link_trailer_q;
    assign link_we        = link_we_q;
    assign evt_count      = evt_q;
    assign last_evt_words = last_q;
    assign proto_err      = perr_q;

endmodule

// File: tb/tb_daq_link_adapter.sv
// Directed bench for daq_link_adapter; the link side is checked against an expected-word queue.
module tb_daq_link_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic        in_header, in_trailer, in_valid, in_ready;
    logic [63:0] link_data;
    logic        link_header, link_trailer, link_we;
    logic        link_almost_full, link_ready;
    logic [31:0] evt_count;
    logic [19:0] last_evt_words;
    logic        proto_err, err_clr;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wcount = 0;
    int          first_we_cyc = -1;
    int          acc_cyc = 0;
    int          base;
    logic [65:0] exp_q [$];
    logic [65:0] e;

    daq_link_adapter #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_header(in_header), .in_trailer(in_trailer),
        .in_valid(in_valid), .in_ready(in_ready),
        .link_data(link_data), .link_header(link_header), .link_trailer(link_trailer),
        .link_we(link_we), .link_almost_full(link_almost_full), .link_ready(link_ready),
        .evt_count(evt_count), .last_evt_words(last_evt_words),
        .proto_err(proto_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Link-side monitor: every write must match the next expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && link_we === 1'b1) begin
            wcount++;
            if (first_we_cyc < 0) first_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_we", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("link_data", link_data, e[63:0]);
                check("link_flags", {62'd0, link_header, link_trailer}, {62'd0, e[65:64]});
            end
        end
    end

    function automatic logic [63:0] exp_trl(input logic [63:0] d, input logic [19:0] n);
        logic [63:0] r;
        r = d;
`ifdef DAQ_TRAILER_LEN_EN
        r[51:32] = n;
`endif
        return r;
    endfunction

    task automatic expect_word(input logic [63:0] d, input logic h, input logic t);
        exp_q.push_back({h, t, d});
    endtask

    // Called at a negedge; returns at the negedge after the word is accepted.
    task automatic send(input logic [63:0] d, input logic h, input logic t);
        int n;
        in_data = d; in_header = h; in_trailer = t; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("send_timeout", 64'd1, 64'd0);
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_data = 64'd0; in_header = 1'b0; in_trailer = 1'b0; in_valid = 1'b0;
        link_almost_full = 1'b0; link_ready = 1'b1; err_clr = 1'b0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_link_we", 64'(link_we), 64'd0);
        check("rst_evt_count", 64'(evt_count), 64'd0);
        check("rst_last_words", 64'(last_evt_words), 64'd0);
        check("rst_proto_err", 64'(proto_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("in_ready_before_clk", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("in_ready_after_clk", 64'(in_ready), 64'd1);

        // Basic event with latency check
        first_we_cyc = -1;
        expect_word(64'hA000_0000_0000_0000, 1'b1, 1'b0);
        expect_word(64'h1, 1'b0, 1'b0);
        expect_word(64'h2, 1'b0, 1'b0);
        expect_word(64'h3, 1'b0, 1'b0);
        expect_word(exp_trl(64'hF000_0000_0000_00FF, 20'd5), 1'b0, 1'b1);
        send(64'hA000_0000_0000_0000, 1'b1, 1'b0);
        base = acc_cyc;
        send(64'h1, 1'b0, 1'b0);
        send(64'h2, 1'b0, 1'b0);
        send(64'h3, 1'b0, 1'b0);
        send(64'hF000_0000_0000_00FF, 1'b0, 1'b1);
        wait_drain();
        check("t1_latency", 64'(first_we_cyc - base), 64'd2);
        check("t1_writes", 64'(wcount), 64'd5);
        check("t1_evt_count", 64'(evt_count), 64'd1);
        check("t1_last_words", 64'(last_evt_words), 64'd5);

        // Fill the FIFO under almost-full, then release
        link_almost_full = 1'b1;
        base = wcount;
        for (int i = 0; i < 20; i++) begin
            logic [63:0] w;
            logic h, t;
            h = (i == 0);
            t = (i == 19);
            w = h ? 64'h1000_0000_0000_0000 : (t ? 64'h2000_0000_0000_0000 : 64'h100 + 64'(i));
            expect_word(t ? exp_trl(w, 20'd20) : w, h, t);
            if (i == 16) begin
                check("t2_full_in_ready", 64'(in_ready), 64'd0);
                check("t2_held_writes", 64'(wcount - base), 64'd0);
                link_almost_full = 1'b0;
            end
            send(w, h, t);
        end
        wait_drain();
        check("t2_writes", 64'(wcount - base), 64'd20);
        check("t2_evt_count", 64'(evt_count), 64'd2);
        check("t2_last_words", 64'(last_evt_words), 64'd20);

        // Orphan data word
        base = wcount;
        send(64'hDEAD, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("t3_proto_err", 64'(proto_err), 64'd1);
        check("t3_no_write", 64'(wcount - base), 64'd0);
        check("t3_evt_count", 64'(evt_count), 64'd2);
        pulse_clr();
        check("t3_err_clr", 64'(proto_err), 64'd0);

        // Header inside an open event
        base = wcount;
        expect_word(64'hB000_0000_0000_0001, 1'b1, 1'b0);
        expect_word(64'h11, 1'b0, 1'b0);
        expect_word(64'h12, 1'b0, 1'b0);
        expect_word(64'hB000_0000_0000_0002, 1'b1, 1'b0);
        expect_word(64'h13, 1'b0, 1'b0);
        expect_word(exp_trl(64'hC000_0000_0000_0000, 20'd3), 1'b0, 1'b1);
        send(64'hB000_0000_0000_0001, 1'b1, 1'b0);
        send(64'h11, 1'b0, 1'b0);
        send(64'h12, 1'b0, 1'b0);
        send(64'hB000_0000_0000_0002, 1'b1, 1'b0);
        send(64'h13, 1'b0, 1'b0);
        send(64'hC000_0000_0000_0000, 1'b0, 1'b1);
        wait_drain();
        check("t4_proto_err", 64'(proto_err), 64'd1);
        check("t4_writes", 64'(wcount - base), 64'd6);
        check("t4_evt_count", 64'(evt_count), 64'd3);
        check("t4_last_words", 64'(last_evt_words), 64'd3);
        pulse_clr();

        // Header and trailer together are dropped
        base = wcount;
        send(64'h5555, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("t4b_proto_err", 64'(proto_err), 64'd1);
        check("t4b_no_write", 64'(wcount - base), 64'd0);
        pulse_clr();

        // Reset with a partial event buffered
        link_almost_full = 1'b1;
        base = wcount;
        send(64'hE000_0000_0000_0000, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) send(64'h200 + 64'(i), 1'b0, 1'b0);
        check("t5_buffered_no_write", 64'(wcount - base), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_link_we", 64'(link_we), 64'd0);
        check("t5_async_in_ready", 64'(in_ready), 64'd0);
        check("t5_async_evt_count", 64'(evt_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        link_almost_full = 1'b0;
        @(negedge clk);
        base = wcount;
        expect_word(64'hE100_0000_0000_0000, 1'b1, 1'b0);
        expect_word(64'h301, 1'b0, 1'b0);
        expect_word(64'h302, 1'b0, 1'b0);
        expect_word(exp_trl(64'hE200_0000_0000_0000, 20'd4), 1'b0, 1'b1);
        send(64'hE100_0000_0000_0000, 1'b1, 1'b0);
        send(64'h301, 1'b0, 1'b0);
        send(64'h302, 1'b0, 1'b0);
        send(64'hE200_0000_0000_0000, 1'b0, 1'b1);
        wait_drain();
        check("t5_writes", 64'(wcount - base), 64'd4);
        check("t5_evt_count", 64'(evt_count), 64'd1);
        check("t5_last_words", 64'(last_evt_words), 64'd4);
        check("t5_proto_err", 64'(proto_err), 64'd0);

        // Ten-word event with a hand-computed trailer
        base = wcount;
        expect_word(64'h7000_0000_0000_0000, 1'b1, 1'b0);
        for (int i = 1; i < 9; i++) expect_word(64'h400 + 64'(i), 1'b0, 1'b0);
`ifdef DAQ_TRAILER_LEN_EN
        expect_word(64'h0000_000A_0200_0008, 1'b0, 1'b1);
`else
        expect_word(64'h0000_0000_0200_0008, 1'b0, 1'b1);
`endif
        send(64'h7000_0000_0000_0000, 1'b1, 1'b0);
        for (int i = 1; i < 9; i++) send(64'h400 + 64'(i), 1'b0, 1'b0);
        send(64'h0000_0000_0200_0008, 1'b0, 1'b1);
        wait_drain();
        check("t6_writes", 64'(wcount - base), 64'd10);
        check("t6_evt_count", 64'(evt_count), 64'd2);
        check("t6_last_words", 64'(last_evt_words), 64'd10);
        check("exp_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
